// File: rtl/car_lane_renderer.sv
// car_lane_renderer: per-pixel car/road mask for the scrolling car lanes,
// per-lane scroll offsets advanced once per frame, and a per-frame
// chicken/car collision flag. Outputs carry one cycle of latency.
// Optional feature: define CAR_GAP_EN to suppress one car slot per lane.
module car_lane_renderer #(
  parameter int LANE_TOP    = 64,
  parameter int LANE_H_LOG2 = 5,
  parameter int NUM_LANES   = 8,
  parameter int CAR_LEN     = 40,
  parameter int CAR_ROW_LO  = 4,
  parameter int CAR_ROW_HI  = 27,
  parameter int CHICK_SIZE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       run,
  input  logic [9:0] chicken_x,
  input  logic [9:0] chicken_y,
  output logic       car_pix,
  output logic       road_pix,
  output logic       frame_tick,
  output logic       hit
);

  localparam int LANE_H   = 1 << LANE_H_LOG2;
  localparam int LANE_BOT = LANE_TOP + NUM_LANES * LANE_H;
  localparam int LW       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [9:0]             rel;
  logic                   in_band;
  logic [LW-1:0]          lane;
  logic [LANE_H_LOG2-1:0] lrow;
  logic [9:0]             x_eff;
  logic                   car_row;
  logic                   car;
  logic                   chick;
  logic                   tick_cond;
  logic                   acc;
  logic [6:0]             off [NUM_LANES];

  // Lane decode and horizontal car test from the current pixel position
  always_comb begin
    rel     = vpos - 10'(LANE_TOP);
    in_band = ({1'b0, vpos} >= 11'(LANE_TOP)) && ({1'b0, vpos} < 11'(LANE_BOT));
    lane    = rel[LANE_H_LOG2 +: LW];
    lrow    = rel[LANE_H_LOG2-1:0];
    // Even lanes scroll right (subtract offset), odd lanes scroll left
    if (lane[0])
      x_eff = hpos + {3'b000, off[lane]};
    else
      x_eff = hpos - {3'b000, off[lane]};
    car_row = (lrow >= LANE_H_LOG2'(CAR_ROW_LO)) && (lrow <= LANE_H_LOG2'(CAR_ROW_HI));
`ifdef CAR_GAP_EN
    car = in_band && display_on && car_row && (x_eff[6:0] < 7'(CAR_LEN))
          && ((x_eff[9:7] ^ 3'(lane)) != 3'b101);
`else
    car = in_band && display_on && car_row && (x_eff[6:0] < 7'(CAR_LEN));
`endif
  end

  // Chicken hit box and start-of-vblank detection
  always_comb begin
    chick = ({1'b0, hpos} >= {1'b0, chicken_x}) &&
            ({1'b0, hpos} <  ({1'b0, chicken_x} + 11'(CHICK_SIZE))) &&
            ({1'b0, vpos} >= {1'b0, chicken_y}) &&
            ({1'b0, vpos} <  ({1'b0, chicken_y} + 11'(CHICK_SIZE)));
    tick_cond = (hpos == 10'd0) && (vpos == 10'd480);
  end

  // Registered pixel outputs, frame tick, offset advance and collision accumulation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_pix    <= 1'b0;
      road_pix   <= 1'b0;
      frame_tick <= 1'b0;
      hit        <= 1'b0;
      acc        <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) off[i] <= '0;
    end else begin
      car_pix    <= car;
      road_pix   <= in_band && display_on;
      frame_tick <= tick_cond;
      if (tick_cond) begin
        hit <= acc | (car && chick);
        acc <= 1'b0;
        if (run)
          for (int unsigned i = 0; i < NUM_LANES; i++)
            off[i] <= off[i] + 7'(1 + (i % 3));
      end else begin
        acc <= acc | (car && chick);
      end
    end
  end

endmodule

// File: tb/tb_car_lane_renderer.sv
// tb_car_lane_renderer: directed scoreboard bench for car_lane_renderer.
module tb_car_lane_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       display_on = 1'b0;
  logic       run = 1'b0;
  logic [9:0] chicken_x = 10'd1000;
  logic [9:0] chicken_y = 10'd1000;
  logic       car_pix, road_pix, frame_tick, hit;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_off [8];
  bit m_acc = 0;
  bit m_hit = 0;

  typedef struct {
    int         h;
    int         v;
    logic [3:0] e;  // {car, road, tick, hit}
  } ent_t;
  ent_t sb [$];

  always #5 clk = ~clk;

  car_lane_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .run        (run),
    .chicken_x  (chicken_x),
    .chicken_y  (chicken_y),
    .car_pix    (car_pix),
    .road_pix   (road_pix),
    .frame_tick (frame_tick),
    .hit        (hit)
  );

  function automatic bit m_road(int v, bit de);
    return de && v >= 64 && v < 320;
  endfunction

  function automatic bit m_car(int h, int v, bit de);
    int ln, lr, x;
    if (!m_road(v, de)) return 0;
    ln = (v - 64) / 32;
    lr = (v - 64) % 32;
    if (lr < 4 || lr > 27) return 0;
    if (ln % 2 == 0) x = (h - m_off[ln] + 1024) % 1024;
    else             x = (h + m_off[ln]) % 1024;
    return (x % 128) < 40;
  endfunction

  task automatic chk(string tag, int h, int v, logic obs, logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s h=%0d v=%0d: got %b want %b", tag, h, v, obs, exp);
    end
  endtask

  task automatic check_pending();
    ent_t en;
    if (sb.size() > 0) begin
      en = sb.pop_front();
      chk("car_pix",    en.h, en.v, car_pix,    en.e[3]);
      chk("road_pix",   en.h, en.v, road_pix,   en.e[2]);
      chk("frame_tick", en.h, en.v, frame_tick, en.e[1]);
      chk("hit",        en.h, en.v, hit,        en.e[0]);
    end
  endtask

  task automatic drive(int h, int v, bit de);
    bit c, r, t, ck;
    ent_t en;
    @(negedge clk);
    check_pending();
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    c  = m_car(h, v, de);
    r  = m_road(v, de);
    t  = (h == 0 && v == 480);
    ck = h >= int'(chicken_x) && h < int'(chicken_x) + 16 &&
         v >= int'(chicken_y) && v < int'(chicken_y) + 16;
    if (t) begin
      m_hit = m_acc | (c & ck);
      m_acc = 0;
      if (run) for (int i = 0; i < 8; i++) m_off[i] = (m_off[i] + 1 + i % 3) % 128;
    end else begin
      m_acc = m_acc | (c & ck);
    end
    en.h = h; en.v = v; en.e = {c, r, t, m_hit};
    sb.push_back(en);
  endtask

  task automatic sweep(int v, int h0, int h1, bit de);
    for (int h = h0; h <= h1; h++) drive(h, v, de);
  endtask

  task automatic tick();
    drive(0, 480, 0);
    drive(1, 480, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_pending();
    rst_n = 1'b0;
    display_on = 1'b0;
    hpos = 10'd5;
    vpos = 10'd100;
    @(negedge clk);
    chk("reset_car",  0, 0, car_pix,    1'b0);
    chk("reset_road", 0, 0, road_pix,   1'b0);
    chk("reset_tick", 0, 0, frame_tick, 1'b0);
    chk("reset_hit",  0, 0, hit,        1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) m_off[i] = 0;
    m_acc = 0;
    m_hit = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_off[i] = 0;

    // reset, then base pattern in lane 0
    do_reset();
    sweep(68, 0, 639, 1);

    // band edges, rows outside the car rows, blanking
    for (int v = 64; v <= 67; v++) sweep(v, 0, 50, 1);
    sweep(92, 0, 50, 1);
    sweep(63, 0, 50, 1);
    sweep(320, 0, 50, 1);
    sweep(68, 0, 50, 0);

    // one frame tick with run=1
    run = 1'b1;
    tick();
    sweep(68, 0, 639, 1);
    sweep(100, 0, 639, 1);
    sweep(132, 0, 200, 1);

    // 127 more ticks: offsets wrap back to the reset pattern in lane 0
    for (int f = 0; f < 127; f++) tick();
    sweep(68, 0, 639, 1);
    sweep(100, 0, 200, 1);

    // run=0 holds offsets
    run = 1'b0;
    for (int f = 0; f < 5; f++) tick();
    sweep(68, 0, 200, 1);
    sweep(100, 0, 200, 1);
    sweep(228, 0, 200, 1);

    // collision: overlapping chicken, then non-overlapping
    do_reset();
    chicken_x = 10'd10;
    chicken_y = 10'd70;
    sweep(70, 0, 30, 1);
    tick();
    sweep(70, 100, 110, 1);
    chicken_x = 10'd60;
    sweep(70, 0, 100, 1);
    tick();
    sweep(75, 0, 20, 1);

    // mid-frame reset clears offsets and a pending collision
    run = 1'b1;
    tick();
    chicken_x = 10'd10;
    sweep(70, 0, 30, 1);
    do_reset();
    run = 1'b0;
    tick();
    sweep(68, 0, 100, 1);
    sweep(100, 0, 100, 1);

    @(negedge clk);
    check_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
